// File: rtl/float_to_int_pkg.sv
// Shared FPU constants and state encoding for the float->int converter.
package float_to_int_pkg;

  localparam logic [7:0]  FP_BIAS        = 8'd127;
  localparam logic [7:0]  FP_EXP_SPECIAL = 8'hFF;
  localparam logic [31:0] INT32_MIN      = 32'h8000_0000;
  // Exponent at which the mantissa LSB has weight 1, and where |x| reaches 2^31.
  localparam logic [7:0]  EXP_INT_LSB    = FP_BIAS + 8'd23;
  localparam logic [7:0]  EXP_INT_MAX    = FP_BIAS + 8'd31;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_e;

endpackage

// File: rtl/float_to_int_unpack.sv
// Combinational field split of a single-precision operand.
module float_to_int_unpack
  import float_to_int_pkg::*;
(
  input  logic [31:0] value_i,
  output logic        sign_o,
  output logic [7:0]  exp_o,
  output logic [22:0] frac_o,
  output logic        is_zero_or_denormal_o,
  output logic        is_special_o
);

  assign sign_o                = value_i[31];
  assign exp_o                 = value_i[30:23];
  assign frac_o                = value_i[22:0];
  assign is_zero_or_denormal_o = (value_i[30:23] == 8'd0);
  assign is_special_o          = (value_i[30:23] == FP_EXP_SPECIAL);

endmodule

// File: rtl/float_to_int.sv
// Float -> int32 cast, truncating; denormalizes with an iterative right shift.
module float_to_int
  import float_to_int_pkg::*;
#(
  parameter int STEP = 8
) (
  input  logic        clk,
  input  logic        clr,
  input  logic        start,
  input  logic [31:0] value_in,
  output logic [31:0] result,
  output logic        done,
  output logic        busy,
  output logic        invalid,
  output logic        inexact
);

  // rem never exceeds 23, so clamping STEP to 31 keeps min(rem,STEP) exact in 5 bits.
  localparam int         STEP_C = (STEP > 31) ? 31 : STEP;
  localparam logic [4:0] STEP5  = 5'(STEP_C);

  logic        u_sign, u_zd, u_special;
  logic [7:0]  u_exp;
  logic [22:0] u_frac;

  float_to_int_unpack u_unpack (
    .value_i               (value_in),
    .sign_o                (u_sign),
    .exp_o                 (u_exp),
    .frac_o                (u_frac),
    .is_zero_or_denormal_o (u_zd),
    .is_special_o          (u_special)
  );

  state_e      state_q, state_d;
  logic [31:0] mag_q, mag_d;
  logic [4:0]  rem_q, rem_d;
  logic        sticky_q, sticky_d;
  logic        s_q, s_d;
  logic        inv_q, inv_d;
  logic [31:0] result_q, result_d;
  logic        done_q, done_d;
  logic        invalid_q, invalid_d;
  logic        inexact_q, inexact_d;

  logic [31:0] dec_mag, mant;
  logic [4:0]  dec_rem;
  logic        dec_sticky, dec_inv, dec_s;

  always_comb begin
    mant       = {8'd0, 1'b1, u_frac};
    dec_mag    = 32'd0;
    dec_rem    = 5'd0;
    dec_sticky = 1'b0;
    dec_inv    = 1'b0;
    dec_s      = u_sign;
    if (u_zd) begin
      dec_sticky = (u_frac != 23'd0);
    end else if (u_special || (u_exp > EXP_INT_MAX) ||
                 ((u_exp == EXP_INT_MAX) && !(u_sign && (u_frac == 23'd0)))) begin
      dec_mag = INT32_MIN;
      dec_s   = 1'b0;
      dec_inv = 1'b1;
    end else if (u_exp < FP_BIAS) begin
      dec_sticky = 1'b1;
    end else if (u_exp == EXP_INT_MAX) begin
      dec_mag = INT32_MIN;
    end else if (u_exp >= EXP_INT_LSB) begin
      dec_mag = mant << 3'(u_exp - EXP_INT_LSB);
    end else begin
      dec_mag = mant;
      dec_rem = 5'(EXP_INT_LSB - u_exp);
    end
  end

  logic [4:0]  amt;
  logic [31:0] lost_mask;

  assign amt       = (rem_q > STEP5) ? STEP5 : rem_q;
  assign lost_mask = (32'd1 << amt) - 32'd1;

  always_comb begin
    state_d   = state_q;
    mag_d     = mag_q;
    rem_d     = rem_q;
    sticky_d  = sticky_q;
    s_d       = s_q;
    inv_d     = inv_q;
    result_d  = result_q;
    invalid_d = invalid_q;
    inexact_d = inexact_q;
    done_d    = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          mag_d    = dec_mag;
          rem_d    = dec_rem;
          sticky_d = dec_sticky;
          s_d      = dec_s;
          inv_d    = dec_inv;
          state_d  = SHIFT;
        end
      end
      SHIFT: begin
        if (rem_q != 5'd0) begin
          mag_d    = mag_q >> amt;
          rem_d    = rem_q - amt;
          sticky_d = sticky_q | (|(mag_q & lost_mask));
        end else begin
          // Negating INT32_MIN wraps back to itself, which is the wanted answer.
          result_d  = s_q ? -mag_q : mag_q;
          inexact_d = sticky_q;
          invalid_d = inv_q;
          done_d    = 1'b1;
          state_d   = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      state_q   <= IDLE;
      mag_q     <= 32'd0;
      rem_q     <= 5'd0;
      sticky_q  <= 1'b0;
      s_q       <= 1'b0;
      inv_q     <= 1'b0;
      result_q  <= 32'd0;
      done_q    <= 1'b0;
      invalid_q <= 1'b0;
      inexact_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      mag_q     <= mag_d;
      rem_q     <= rem_d;
      sticky_q  <= sticky_d;
      s_q       <= s_d;
      inv_q     <= inv_d;
      result_q  <= result_d;
      done_q    <= done_d;
      invalid_q <= invalid_d;
      inexact_q <= inexact_d;
    end
  end

  assign result  = result_q;
  assign done    = done_q;
  assign busy    = (state_q == SHIFT);
  assign invalid = invalid_q;
  assign inexact = inexact_q;

endmodule

// File: tb/tb_float_to_int.sv
// Bench for float_to_int: directed table, random vs. arithmetic model, handshake and reset sequences.
module tb_float_to_int;

  logic        clk = 1'b0;
  logic        clr = 1'b0;
  logic        start = 1'b0;
  logic [31:0] value_in = 32'd0;
  logic [31:0] result;
  logic        done, busy, invalid, inexact;

  float_to_int #(.STEP(8)) dut (
    .clk      (clk),
    .clr      (clr),
    .start    (start),
    .value_in (value_in),
    .result   (result),
    .done     (done),
    .busy     (busy),
    .invalid  (invalid),
    .inexact  (inexact)
  );

  always #5 clk = ~clk;

  int n_pass = 0;
  int n_tot  = 0;

  localparam longint IMAX = 64'sh7FFF_FFFF;
  localparam longint IMIN = -64'sh8000_0000;

  typedef struct {
    logic [31:0] v;
    logic [31:0] res;
    logic        inv;
    logic        inx;
    int          lat;
  } vec_t;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tot++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h want %h", nm, act, exp);
  endtask

  // Value = (-1)^s * 1.F * 2^e; truncate toward zero, then range-check the signed result.
  task automatic model(input logic [31:0] v, output logic [31:0] r, output logic iv,
                       output logic ix, output int n);
    int     e;
    longint m, mag, val;
    e  = int'(v[30:23]) - 127;
    m  = {40'd0, 1'b1, v[22:0]};
    r  = 32'd0; iv = 1'b0; ix = 1'b0; n = 1;
    if (v[30:23] == 8'hFF || e > 31) begin
      iv = 1'b1; r = 32'h8000_0000;
    end else if (v[30:23] == 8'd0) begin
      ix = (v[22:0] != 23'd0);
    end else if (e < 0) begin
      ix = 1'b1;
    end else begin
      if (e >= 23) mag = m <<< (e - 23);
      else begin
        mag = m >>> (23 - e);
        ix  = ((mag <<< (23 - e)) != m);
        n   = 1 + (23 - e + 7) / 8;
      end
      val = v[31] ? -mag : mag;
      if (val > IMAX || val < IMIN) begin
        iv = 1'b1; ix = 1'b0; r = 32'h8000_0000;
      end else r = val[31:0];
    end
  endtask

  // Issue one conversion from idle and report outputs, latency and busy-cycle count.
  task automatic convert(input logic [31:0] v, output logic [31:0] r, output logic iv,
                         output logic ix, output int n, output int bcnt);
    int g = 0;
    while (busy && g < 40) begin @(posedge clk); #1; g++; end
    @(posedge clk); #1;
    start = 1'b1; value_in = v;
    @(posedge clk); #1;
    start = 1'b0;
    n = 0;
    bcnt = busy ? 1 : 0;
    while (!done && n < 20) begin
      @(posedge clk); #1;
      n++;
      if (busy) bcnt++;
    end
    r = result; iv = invalid; ix = inexact;
  endtask

  vec_t tbl[$];

  initial begin
    logic [31:0] r, er, v;
    logic        iv, ix, eiv, eix;
    int          n, en, bcnt, ndone, g;
    string       tag;

    tbl = '{
      '{32'h3F80_0000, 32'h0000_0001, 1'b0, 1'b0, 4},
      '{32'hC020_0000, 32'hFFFF_FFFE, 1'b0, 1'b1, 4},
      '{32'h4EFF_FFFF, 32'h7FFF_FF80, 1'b0, 1'b0, 1},
      '{32'hCF00_0000, 32'h8000_0000, 1'b0, 1'b0, 1},
      '{32'h4F00_0000, 32'h8000_0000, 1'b1, 1'b0, 1},
      '{32'h7FC0_0000, 32'h8000_0000, 1'b1, 1'b0, 1},
      '{32'hFF80_0000, 32'h8000_0000, 1'b1, 1'b0, 1},
      '{32'h3F00_0000, 32'h0000_0000, 1'b0, 1'b1, 1},
      '{32'h8000_0000, 32'h0000_0000, 1'b0, 1'b0, 1},
      '{32'h0000_0001, 32'h0000_0000, 1'b0, 1'b1, 1},
      '{32'h4049_0FDB, 32'h0000_0003, 1'b0, 1'b1, 4},
      '{32'h4B00_0000, 32'h0080_0000, 1'b0, 1'b0, 1},
      '{32'h4A80_0000, 32'h0040_0000, 1'b0, 1'b0, 2},
      '{32'h4780_0000, 32'h0001_0000, 1'b0, 1'b0, 2},
      '{32'h4300_0000, 32'h0000_0080, 1'b0, 1'b0, 3},
      '{32'h4120_0000, 32'h0000_000A, 1'b0, 1'b0, 4},
      '{32'h3FFF_FFFF, 32'h0000_0001, 1'b0, 1'b1, 4},
      '{32'hCF00_0001, 32'h8000_0000, 1'b1, 1'b0, 1}
    };

    #12;
    chk("rst_result", result, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_flags", {30'd0, invalid, inexact}, 32'd0);
    #3 clr = 1'b1;

    foreach (tbl[i]) begin
      convert(tbl[i].v, r, iv, ix, n, bcnt);
      tag = $sformatf("vec%0d_%h", i, tbl[i].v);
      chk({tag, "_res"}, r, tbl[i].res);
      chk({tag, "_inv"}, {31'd0, iv}, {31'd0, tbl[i].inv});
      chk({tag, "_inx"}, {31'd0, ix}, {31'd0, tbl[i].inx});
      chk({tag, "_lat"}, n, tbl[i].lat);
      chk({tag, "_busy"}, bcnt, tbl[i].lat);
    end

    for (int i = 0; i < 300; i++) begin
      v = $urandom;
      if (i % 3 != 0) v[30:23] = 8'($urandom_range(110, 165));
      model(v, er, eiv, eix, en);
      convert(v, r, iv, ix, n, bcnt);
      tag = $sformatf("rnd%0d_%h", i, v);
      chk({tag, "_res"}, r, er);
      chk({tag, "_flags"}, {30'd0, iv, ix}, {30'd0, eiv, eix});
      chk({tag, "_lat"}, n, en);
    end

    // Start asserted while busy must be ignored, not queued.
    @(posedge clk); #1;
    start = 1'b1; value_in = 32'h3F80_0000;
    @(posedge clk); #1;
    value_in = 32'h4EFF_FFFF;
    @(posedge clk); #1;
    start = 1'b0;
    ndone = 0; r = 32'hDEAD_BEEF;
    for (int c = 0; c < 12; c++) begin
      @(posedge clk); #1;
      if (done) begin ndone++; r = result; end
    end
    chk("busy_start_ndone", ndone, 1);
    chk("busy_start_res", r, 32'h1);

    // Back-to-back: new start raised in the done cycle.
    @(posedge clk); #1;
    start = 1'b1; value_in = 32'h4049_0FDB;
    @(posedge clk); #1;
    start = 1'b0;
    g = 0;
    while (!done && g < 20) begin @(posedge clk); #1; g++; end
    chk("b2b_first_res", result, 32'd3);
    chk("b2b_first_busy", {31'd0, busy}, 32'd0);
    start = 1'b1; value_in = 32'h3F80_0000;
    @(posedge clk); #1;
    start = 1'b0;
    chk("b2b_accept_busy", {31'd0, busy}, 32'd1);
    n = 0;
    while (!done && n < 20) begin @(posedge clk); #1; n++; end
    chk("b2b_second_lat", n, 4);
    chk("b2b_second_res", result, 32'd1);

    // Asynchronous reset in the cycle after accept.
    @(posedge clk); #1;
    start = 1'b1; value_in = 32'h3F80_0000;
    @(posedge clk); #1;
    start = 1'b0;
    #3 clr = 1'b0;
    #1;
    chk("mid_rst_busy", {31'd0, busy}, 32'd0);
    chk("mid_rst_done", {31'd0, done}, 32'd0);
    chk("mid_rst_res", result, 32'd0);
    @(posedge clk); #1;
    clr = 1'b1;
    ndone = 0;
    for (int c = 0; c < 10; c++) begin
      @(posedge clk); #1;
      if (done) ndone++;
    end
    chk("mid_rst_no_done", ndone, 0);
    convert(32'h4120_0000, r, iv, ix, n, bcnt);
    chk("post_rst_res", r, 32'd10);
    chk("post_rst_lat", n, 4);

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule
